pulse_length_extender: RTL and testbench
========================================

Name: pulse_length_extender

Overview:
- Retriggerable pulse stretcher in a single clock domain.
- Any cycle in which pulse_in is sampled high produces an output pulse lasting at least PULSE_LENGTH cycles.
- Overlapping or closely spaced input pulses merge into one continuous output pulse.
- Typical use: widening short event strobes ahead of slower logic, LEDs, or status capture.

Parameters:
- PULSE_LENGTH, default 2: minimum output pulse length in clock cycles. Integer ≥ 1. Values < 1 are a configuration error, flagged by an elaboration-time check.

Ports:
- clock  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- pulse_in  input  1  input pulse, sampled on each rising edge of clock; one sample high means one event.
- pulse_out  output  1  extended pulse; driven directly from register state, with no combinational path from pulse_in.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- State is a down-counter, cnt, of width $clog2(PULSE_LENGTH+1) bits, minimum 1 bit.
- Reset: resetn low clears cnt to 0 immediately, regardless of clock, so pulse_out=0 immediately. Reset mid-pulse truncates the pulse; there is no residual extension after release.
- Each rising edge, with resetn high:
  - pulse_in=1: cnt <= PULSE_LENGTH (reload; retrigger allowed at any time).
  - else if cnt != 0: cnt <= cnt-1.
  - else: cnt holds 0.
- pulse_out = (cnt != 0). It is a decode of the register with no glitch-causing input path.
- Latency: pulse_in sampled high at edge k gives pulse_out high from just after edge k until just after edge k+PULSE_LENGTH, where it falls. That is exactly PULSE_LENGTH cycles for an isolated one-cycle input.
- pulse_in high for N consecutive samples gives a single output pulse of N+PULSE_LENGTH-1 cycles.
- Two input highs separated by g low samples:
  - g ≤ PULSE_LENGTH-1: output stays continuously high (merged).
  - g ≥ PULSE_LENGTH: output low for exactly g-PULSE_LENGTH+1 cycles between the two pulses.
- Output pulse length is never shorter than PULSE_LENGTH, except when reset truncates it.
- PULSE_LENGTH=1: pulse_out is pulse_in delayed by one cycle (a pure register).
- No saturation or wrap issues: the counter only loads PULSE_LENGTH or decrements toward 0.
- pulse_in high during reset is ignored. The first sample taken after resetn deasserts is honoured normally.

Test Plan:
- Reset with PULSE_LENGTH=2, pulse_in=0 -> pulse_out=0 during reset and for all cycles after release.
- Single one-cycle pulse, PULSE_LENGTH=2 -> pulse_out high exactly 2 cycles, starting the cycle after the sampling edge, then low. Repeat with PULSE_LENGTH=4 -> high exactly 4 cycles.
- pulse_in held high 4 cycles, PULSE_LENGTH=2 -> one output pulse of 5 cycles, then low.
- Four one-cycle pulses spaced by 1 low cycle, PULSE_LENGTH=2 -> one continuous pulse of 8 cycles. With spacing of 3 low cycles -> four separate 2-cycle pulses with 2-cycle low gaps.
- Assert resetn low mid-pulse (2nd cycle of a PULSE_LENGTH=4 pulse) -> pulse_out drops asynchronously. After release it stays low until the next pulse_in high.
- Random pulse_in (probability 1/PULSE_LENGTH, 1000 cycles), then pulse_in=0 -> every output high run ≥ PULSE_LENGTH cycles. Output matches the reference-model counter each cycle and returns to 0 within PULSE_LENGTH cycles after the stimulus ends.

Source files
------------

// File: rtl/pulse_length_extender.sv
// Purpose: retriggerable pulse stretcher; any sampled pulse_in high yields at least PULSE_LENGTH cycles of pulse_out.
// Latency: pulse_out rises one cycle after pulse_in is sampled high and stays high PULSE_LENGTH cycles past the last high sample.
// Backpressure: none; pulse_in is sampled every cycle and pulses closer together than PULSE_LENGTH merge into one output pulse.
module pulse_length_extender #(
  parameter int PULSE_LENGTH = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic pulse_in,
  output logic pulse_out
);

  // Counter must hold the value PULSE_LENGTH itself; never narrower than one bit.
  localparam int CW = (PULSE_LENGTH < 1) ? 1 : $clog2(PULSE_LENGTH + 1);
  localparam logic [CW-1:0] RELOAD = CW'(PULSE_LENGTH);

  // A zero or negative length would make the stretcher a no-op; refuse to build it.
  if (PULSE_LENGTH < 1) begin : g_bad_length
    $error("pulse_length_extender: PULSE_LENGTH must be >= 1");
  end

  // Cycles of output remaining; zero means the output is idle.
  logic [CW-1:0] cnt;

  // Reload on every input high so back-to-back events extend the pulse; otherwise count down to idle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (pulse_in) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Output is a pure decode of the counter register, so it has no path from pulse_in.
  assign pulse_out = (cnt != '0);

endmodule

// File: tb/tb_pulse_length_extender.sv
// Bench for pulse_length_extender: three instances (PULSE_LENGTH 1, 2, 4) share one stimulus stream.
// The reference model tracks only the edge index of the most recent accepted event.
// Expected outputs are queued per edge and checked by an independent monitor process.
module tb_pulse_length_extender;

  localparam int NDUT = 3;
  localparam int PLS[NDUT] = '{1, 2, 4};
  localparam longint NEVER = -1000000;

  logic clock;
  logic resetn;
  logic pulse_in;
  logic [NDUT-1:0] outs;

  int checks;
  int failures;

  pulse_length_extender #(.PULSE_LENGTH(1)) u_pl1 (
    .clock(clock), .resetn(resetn), .pulse_in(pulse_in), .pulse_out(outs[0]));
  pulse_length_extender #(.PULSE_LENGTH(2)) u_pl2 (
    .clock(clock), .resetn(resetn), .pulse_in(pulse_in), .pulse_out(outs[1]));
  pulse_length_extender #(.PULSE_LENGTH(4)) u_pl4 (
    .clock(clock), .resetn(resetn), .pulse_in(pulse_in), .pulse_out(outs[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state: edge counter and edge of the last accepted event.
  longint cyc;
  longint last_evt;
  logic [NDUT-1:0] exp_q[$];

  // Apply one cycle of stimulus (changed on the falling edge), then predict the outputs after the rising edge.
  task automatic step(input logic p, input logic r);
    logic [NDUT-1:0] e;
    @(negedge clock);
    pulse_in = p;
    resetn   = r;
    @(posedge clock);
    if (!r) begin
      last_evt = NEVER;
    end else if (p) begin
      last_evt = cyc;
    end
    for (int i = 0; i < NDUT; i++) begin
      e[i] = r && ((cyc - last_evt) < longint'(PLS[i]));
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  // Monitor: one expected vector per rising edge, compared just after the edge; also checks minimum run length.
  int run_len[NDUT];
  logic [NDUT-1:0] prev_out;
  longint mon_cyc;
  initial begin
    for (int i = 0; i < NDUT; i++) run_len[i] = 0;
    prev_out = '0;
    mon_cyc  = 0;
  end

  always begin
    logic [NDUT-1:0] e;
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int i = 0; i < NDUT; i++) begin
        checks++;
        if (outs[i] !== e[i]) begin
          failures++;
          $display("FAIL out_pl%0d edge %0d: got %b expected %b", PLS[i], mon_cyc, outs[i], e[i]);
        end
        if (!resetn) begin
          run_len[i] = 0;
        end else if (outs[i] === 1'b1) begin
          run_len[i]++;
        end else begin
          if (prev_out[i] === 1'b1 && run_len[i] > 0) begin
            checks++;
            if (run_len[i] < PLS[i]) begin
              failures++;
              $display("FAIL runlen_pl%0d edge %0d: got %0d cycles, min %0d", PLS[i], mon_cyc, run_len[i], PLS[i]);
            end
          end
          run_len[i] = 0;
        end
      end
      prev_out = outs;
      mon_cyc++;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    last_evt = NEVER;
    pulse_in = 1'b0;
    resetn   = 1'b0;

    // Reset with idle input, then idle after release.
    #1;
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (outs[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_pl%0d: got %b expected 0", PLS[i], outs[i]);
      end
    end
    repeat (3) step(1'b0, 1'b0);
    idle(3);

    // Isolated single-cycle pulse.
    step(1'b1, 1'b1);
    idle(6);

    // Input held high four cycles.
    repeat (4) step(1'b1, 1'b1);
    idle(6);

    // Four pulses separated by one low cycle.
    repeat (4) begin
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
    end
    idle(6);

    // Four pulses separated by three low cycles.
    repeat (4) begin
      step(1'b1, 1'b1);
      idle(3);
    end
    idle(6);

    // Reset asserted in the second cycle of a pulse: output must drop without a clock edge.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      checks++;
      if (outs[i] !== 1'b0) begin
        failures++;
        $display("FAIL async_reset_pl%0d: got %b expected 0", PLS[i], outs[i]);
      end
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b1);
    idle(6);

    // Random phases: event probability 1/2 then 1/4, then drain.
    for (int i = 0; i < 1000; i++) step(($urandom_range(1, 0) == 0), 1'b1);
    idle(6);
    for (int i = 0; i < 1000; i++) step(($urandom_range(3, 0) == 0), 1'b1);
    idle(8);

    // Every queued expectation must have been consumed by the monitor.
    @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
